// File: rtl/var_delay_line_pkg.sv
// Shared definitions for the variable delay line: tap width helper and the
// build flag mirroring VDL_OCC_COUNT_EN (off unless the macro is defined).
package var_delay_line_pkg;

`ifdef VDL_OCC_COUNT_EN
  localparam bit VDL_OCC_ON = 1'b1;
`else
  localparam bit VDL_OCC_ON = 1'b0;
`endif

  // Bits needed to encode a delay of 0..depth cycles.
  function automatic int vdl_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/var_delay_line_if.sv
// Data/control bundle between a producer and the variable delay line.
interface var_delay_line_if #(
  parameter int N     = 8,
  parameter int SEL_W = 3
);
  logic             E;
  logic             Flush;
  logic [N-1:0]     D;
  logic             Vin;
  logic [SEL_W-1:0] Tap;
  logic [N-1:0]     Q;
  logic             Vout;
  logic [SEL_W-1:0] Occ;

  modport master (output E, Flush, D, Vin, Tap, input Q, Vout, Occ);
  modport slave  (input E, Flush, D, Vin, Tap, output Q, Vout, Occ);
endinterface

// File: rtl/var_delay_line_chk.sv
// Simulation checks for the delay line occupancy counter.
module var_delay_line_chk #(
  parameter int DEPTH = 4,
  parameter int SEL_W = 3
) (
  input logic             Clock,
  input logic             Resetn,
  input logic [SEL_W-1:0] occ
);
  a_occ_bound: assert property (@(posedge Clock) disable iff (!Resetn)
                                occ <= SEL_W'(DEPTH));
endmodule

// File: rtl/var_delay_line_stage.sv
// One delay stage: W-bit register with synchronous reset, clear and enable.
module vdl_stage #(
  parameter int W = 9
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         E,
  input  logic         Flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_r;

  // Stage register; Resetn beats Flush, Flush beats the enable.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      q_r <= {W{1'b0}};
    end else if (Flush) begin
      q_r <= {W{1'b0}};
    end else if (E) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/var_delay_line.sv
// Runtime-tappable delay line (0..DEPTH cycles) with valid tracking, stall and
// flush. Define VDL_OCC_COUNT_EN to build the valid-stage occupancy counter.
module var_delay_line
  import var_delay_line_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = vdl_sel_w(DEPTH)
) (
  input logic              Clock,
  input logic              Resetn,
  var_delay_line_if.slave  bus
);
  // Each stage word is {valid, data}.
  logic [N:0]   stage_q_s [DEPTH];
  logic [N:0]   sel_s;
  logic [N-1:0] q_s;
  logic         vout_s;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [N:0] stage_d_s;
    if (k == 0) begin : g_head
      assign stage_d_s = {bus.Vin, bus.D};
    end else begin : g_tail
      assign stage_d_s = stage_q_s[k-1];
    end
    vdl_stage #(.W(N + 1)) u_stage (
      .Clock  (Clock),
      .Resetn (Resetn),
      .E      (bus.E),
      .Flush  (bus.Flush),
      .d      (stage_d_s),
      .q      (stage_q_s[k])
    );
  end

  // Tap mux: 0 bypasses, 1..DEPTH pick a stage, anything larger clamps to the last.
  always_comb begin
    sel_s = stage_q_s[DEPTH-1];
    for (int k = 0; k < DEPTH - 1; k++) begin
      sel_s = (bus.Tap == SEL_W'(k + 1)) ? stage_q_s[k] : sel_s;
    end
    if (bus.Tap == {SEL_W{1'b0}}) begin
      q_s    = bus.D;
      vout_s = bus.Vin;
    end else begin
      q_s    = sel_s[N-1:0];
      vout_s = sel_s[N];
    end
  end

  assign bus.Q    = q_s;
  assign bus.Vout = vout_s;

`ifdef VDL_OCC_COUNT_EN
  logic [SEL_W-1:0] occ_r;

  // Occupancy: one in at stage 0, one out when the oldest valid word falls off.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      occ_r <= {SEL_W{1'b0}};
    end else if (bus.Flush) begin
      occ_r <= {SEL_W{1'b0}};
    end else if (bus.E) begin
      occ_r <= occ_r + SEL_W'(bus.Vin) - SEL_W'(stage_q_s[DEPTH-1][N]);
    end else begin
      occ_r <= occ_r;
    end
  end

  assign bus.Occ = occ_r;
`else
  assign bus.Occ = {SEL_W{1'b0}};
`endif

  var_delay_line_chk #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_chk (
    .Clock  (Clock),
    .Resetn (Resetn),
    .occ    (bus.Occ)
  );
endmodule

// File: tb/tb_var_delay_line.sv
// Directed self-checking bench for var_delay_line (N=8, DEPTH=4, SEL_W=3).
module tb_var_delay_line;
  import var_delay_line_pkg::*;

  logic Clock;
  logic Resetn;
  int   vectors;
  int   miscompares;

  var_delay_line_if #(.N(8), .SEL_W(3)) bus ();

  var_delay_line #(.N(8), .DEPTH(4), .SEL_W(3)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Occupancy is only counted when the feature is built in.
  function automatic logic [2:0] eocc(input int n);
    return VDL_OCC_ON ? 3'(n) : 3'd0;
  endfunction

  task automatic test_reset();
    Resetn = 1'b0; bus.E = 1'b1; bus.Flush = 1'b0;
    bus.Vin = 1'b1; bus.D = 8'hAA; bus.Tap = 3'd2;
    tick(); tick();
    vectors++; if (bus.Q !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %h expected 00", bus.Q); end
    vectors++; if (bus.Vout !== 1'b0) begin miscompares++; $display("FAIL reset_vout: got %b expected 0", bus.Vout); end
    vectors++; if (bus.Occ !== 3'd0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", bus.Occ); end
    Resetn = 1'b1;
    tick();
    vectors++; if (bus.Vout !== 1'b0) begin miscompares++; $display("FAIL reset_rel1_vout: got %b expected 0", bus.Vout); end
    bus.Vin = 1'b0; bus.D = 8'h00;
    tick();
    vectors++; if (bus.Q !== 8'hAA || bus.Vout !== 1'b1) begin
      miscompares++; $display("FAIL reset_rel2: got q=%h v=%b expected q=aa v=1", bus.Q, bus.Vout);
    end
    vectors++; if (bus.Occ !== eocc(1)) begin miscompares++; $display("FAIL reset_rel2_occ: got %0d expected %0d", bus.Occ, eocc(1)); end
  endtask

  task automatic test_latency();
    bus.Flush = 1'b1; bus.E = 1'b1; bus.Vin = 1'b1; bus.D = 8'h00;
    tick();
    bus.Flush = 1'b0; bus.Tap = 3'd3;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] eq;
      logic       ev;
      bus.D = 8'(i + 1);
      tick();
      eq = (i >= 2) ? 8'(i - 1) : 8'h00;
      ev = (i >= 2);
      vectors++; if (bus.Q !== eq || bus.Vout !== ev) begin
        miscompares++; $display("FAIL latency_%0d: got q=%h v=%b expected q=%h v=%b", i, bus.Q, bus.Vout, eq, ev);
      end
      vectors++; if (bus.Occ !== eocc((i + 1 > 4) ? 4 : i + 1)) begin
        miscompares++; $display("FAIL latency_occ_%0d: got %0d expected %0d", i, bus.Occ, eocc((i + 1 > 4) ? 4 : i + 1));
      end
    end
  endtask

  task automatic test_stall();
    bus.E = 1'b0; bus.D = 8'hFF; bus.Vin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (bus.Q !== 8'h04 || bus.Vout !== 1'b1 || bus.Occ !== eocc(4)) begin
        miscompares++; $display("FAIL stall_hold_%0d: got q=%h v=%b occ=%0d expected q=04 v=1 occ=%0d", i, bus.Q, bus.Vout, bus.Occ, eocc(4));
      end
    end
    bus.E = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.D = 8'(7 + j);
      tick();
      vectors++; if (bus.Q !== 8'(5 + j) || bus.Vout !== 1'b1) begin
        miscompares++; $display("FAIL stall_resume_%0d: got q=%h v=%b expected q=%h v=1", j, bus.Q, bus.Vout, 8'(5 + j));
      end
    end
  endtask

  task automatic test_bypass_clamp();
    bus.E = 1'b0; bus.Tap = 3'd0; bus.D = 8'h5A; bus.Vin = 1'b1;
    #1;
    vectors++; if (bus.Q !== 8'h5A || bus.Vout !== 1'b1) begin
      miscompares++; $display("FAIL bypass: got q=%h v=%b expected q=5a v=1", bus.Q, bus.Vout);
    end
    bus.Vin = 1'b0;
    #1;
    vectors++; if (bus.Vout !== 1'b0) begin miscompares++; $display("FAIL bypass_vin0: got %b expected 0", bus.Vout); end
    bus.Tap = 3'd4;
    #1;
    vectors++; if (bus.Q !== 8'h06 || bus.Vout !== 1'b1) begin
      miscompares++; $display("FAIL tap4: got q=%h v=%b expected q=06 v=1", bus.Q, bus.Vout);
    end
    bus.Tap = 3'd7;
    #1;
    vectors++; if (bus.Q !== 8'h06 || bus.Vout !== 1'b1) begin
      miscompares++; $display("FAIL clamp7: got q=%h v=%b expected q=06 v=1", bus.Q, bus.Vout);
    end
    bus.Tap = 3'd5;
    #1;
    vectors++; if (bus.Q !== 8'h06) begin miscompares++; $display("FAIL clamp5: got %h expected 06", bus.Q); end
    bus.Tap = 3'd1;
    #1;
    vectors++; if (bus.Q !== 8'h09) begin miscompares++; $display("FAIL retap1: got %h expected 09", bus.Q); end
    bus.E = 1'b1; bus.Vin = 1'b0; bus.D = 8'h3C;
    tick();
    vectors++; if (bus.Q !== 8'h3C || bus.Vout !== 1'b0) begin
      miscompares++; $display("FAIL invalid_shift: got q=%h v=%b expected q=3c v=0", bus.Q, bus.Vout);
    end
    vectors++; if (bus.Occ !== eocc(3)) begin miscompares++; $display("FAIL invalid_shift_occ: got %0d expected %0d", bus.Occ, eocc(3)); end
  endtask

  task automatic test_flush();
    bus.E = 1'b1; bus.Vin = 1'b1;
    bus.D = 8'h0A; tick();
    bus.D = 8'h0B; tick();
    bus.Flush = 1'b1; bus.D = 8'h77;
    tick();
    bus.Flush = 1'b0; bus.E = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      bus.Tap = 3'(t);
      #1;
      vectors++; if (bus.Q !== 8'h00 || bus.Vout !== 1'b0) begin
        miscompares++; $display("FAIL flush_tap%0d: got q=%h v=%b expected q=00 v=0", t, bus.Q, bus.Vout);
      end
    end
    vectors++; if (bus.Occ !== 3'd0) begin miscompares++; $display("FAIL flush_occ: got %0d expected 0", bus.Occ); end
  endtask

  task automatic test_reset_mid();
    bus.E = 1'b1; bus.Vin = 1'b1; bus.Tap = 3'd2;
    bus.D = 8'h11; tick();
    bus.D = 8'h22; tick();
    bus.D = 8'h33; tick();
    Resetn = 1'b0; bus.Flush = 1'b1; bus.D = 8'h44;
    tick();
    Resetn = 1'b1; bus.Flush = 1'b0; bus.E = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      bus.Tap = 3'(t);
      #1;
      vectors++; if (bus.Q !== 8'h00 || bus.Vout !== 1'b0) begin
        miscompares++; $display("FAIL rstmid_tap%0d: got q=%h v=%b expected q=00 v=0", t, bus.Q, bus.Vout);
      end
    end
    vectors++; if (bus.Occ !== 3'd0) begin miscompares++; $display("FAIL rstmid_occ: got %0d expected 0", bus.Occ); end
    bus.E = 1'b1; bus.Tap = 3'd1; bus.D = 8'h55;
    tick();
    vectors++; if (bus.Q !== 8'h55 || bus.Vout !== 1'b1 || bus.Occ !== eocc(1)) begin
      miscompares++; $display("FAIL rstmid_resume: got q=%h v=%b occ=%0d expected q=55 v=1 occ=%0d", bus.Q, bus.Vout, bus.Occ, eocc(1));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Resetn = 1'b0;
    bus.E = 1'b0; bus.Flush = 1'b0; bus.D = 8'h00; bus.Vin = 1'b0; bus.Tap = 3'd0;
    #1;
    test_reset();
    test_latency();
    test_stall();
    test_bypass_clamp();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/var_delay_line.md
Name: var_delay_line

Overview:
Parametrised, runtime-tappable delay line with per-stage valid tracking, stall and flush. Generalises the fixed single-cycle delay register to N bits by DEPTH stages. The delay (0..DEPTH cycles) is selected per cycle by a tap input. Used to align datapath signals (pixel addresses, colour, write-enables) with memory read latency between the VGA/object-memory path and drawing FSMs.

Parameters:
N, 8, data width in bits (>=1)
DEPTH, 4, number of register stages = maximum delay (>=1)
SEL_W, 3, width of Tap and Occ; must satisfy 2**SEL_W > DEPTH

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  synchronous active-low reset
E  input  1  advance enable; 0 = stall (all stages hold)
Flush  input  1  synchronous clear of all valid bits and data
D  input  N  data in
Vin  input  1  valid qualifier for D
Tap  input  SEL_W  selected delay in cycles
Q  output  N  delayed data
Vout  output  1  valid qualifier for Q
Occ  output  SEL_W  count of valid stages (see Optional Feature)

Behaviour:
- Reset: Clock is Clock; reset is Resetn, synchronous, active-low. On an edge with Resetn=0, all stage data <= 0, all stage valids <= 0, Occ <= 0. Reset overrides Flush and E.
- Storage: stage[0..DEPTH-1], each holding N data bits plus 1 valid bit.
- Advance (Resetn=1, Flush=0, E=1) at each edge:
  - stage[0] <= {Vin, D}
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1
  - the oldest entry, stage[DEPTH-1], is discarded.
- Stall (E=0, Flush=0): every stage holds its value. A stall does not change Q or Vout unless Tap changes.
- Flush (Resetn=1, Flush=1): all data and valids <= 0 regardless of E. D/Vin presented in that cycle are dropped.
- Output selection is combinational from Tap:
  - Tap=0: Q=D, Vout=Vin (bypass, zero latency).
  - Tap=t with 1<=t<=DEPTH: Q=stage[t-1].data, Vout=stage[t-1].valid.
  - Tap>DEPTH: clamped to DEPTH; no X and no wrap.
- Latency: with E held high, a word presented at edge k appears on Q after edge k+Tap-1, i.e. during cycle k+Tap.
- Tap changed mid-stream: Q immediately reflects the newly selected stage. No data reordering or refill.
- Vin=0 words still shift. Their data is carried and Vout=0 marks them invalid.
- After reset or flush, Q=0 and Vout=0 for every Tap>=1 until valid data reaches the selected stage.

Optional Feature:
Macro VDL_OCC_COUNT_EN.
- Defined: Occ is a registered counter of the valid bits in stage[0..DEPTH-1].
  - On an advance edge: Occ <= Occ + Vin - stage[DEPTH-1].valid.
  - Unchanged on stall.
  - 0 on Flush or reset.
  - Bounded 0..DEPTH by construction; an assertion checks the bound in simulation.
- Undefined: Occ is tied to 0 and no counter logic is synthesised. The port list is identical in both builds.

Decomposition:
- Shared include/package (utils header): localparam helper for SEL_W computation (ceil log2 of DEPTH+1) and the VDL_OCC_COUNT_EN default-off guard.
- One natural sub-module: vdl_stage, an N+1-bit register with Resetn, E and Flush (regn plus a synchronous clear). It is instantiated DEPTH times via generate.
- The tap mux and clamp live in the top module.

Test Plan:
- Reset: Resetn=0 for 2 edges with E=1, Vin=1, D=8'hAA, Tap=2 -> Q=8'h00, Vout=0, Occ=0; after release, the first valid word appears 2 cycles later.
- Latency: Tap=3, E=1, Vin=1, D=01,02,03,04 on successive edges -> Q=01 with Vout=1 in the cycle after the 3rd edge, then 02, 03, 04 consecutively; Occ counts 1,2,3,4 then saturates at 4 (DEPTH=4).
- Stall: mid-stream, E=0 for 2 cycles with D=FF -> Q, Vout and Occ held constant; FF never appears at Q; the stream resumes in order when E=1.
- Bypass and clamp:
  - Tap=0, D=5A, Vin=1 -> Q=5A, Vout=1 in the same cycle.
  - Tap=7 (DEPTH=4) -> output identical to Tap=4.
- Flush: with a full line, assert Flush=1 with E=1, D=77 -> next cycle Vout=0 and Q=00 for Tap=1..4, Occ=0; 77 never appears.
- Reset mid-operation: Resetn=0 during streaming with Flush=1 and E=1 simultaneously -> all outputs 0 next cycle, identical to the plain reset result.
